// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants for the multi-port register file
package regfile_mp_pkg;

    // Default register width and address width
    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;

    // Hard-wired zero register address
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - per-register busy bits for RAW hazard detection
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int NWR = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush,
    output logic [(2**AW)-1:0]    busy
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // Next-state per entry: flush beats alloc, alloc beats write-back clear
    always_comb begin
        busy_nxt = busy_q;
        for (int k = 0; k < DEPTH; k++) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == AW'(k))) begin
                    busy_nxt[k] = 1'b0;
                end
            end
            if (alloc_en && (alloc_addr == AW'(k))) begin
                busy_nxt[k] = 1'b1;
            end
            if (flush) begin
                busy_nxt[k] = 1'b0;
            end
        end
        // The zero register never has an outstanding producer
        busy_nxt[REG_ZERO] = 1'b0;
    end

    // Busy state register with asynchronous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with busy scoreboard; REGFILE_BYPASS_EN enables write-through forwarding
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int NRD = 2,
    parameter int NWR = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DW-1:0]     rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DW-1:0]     wdata,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    wa;

    regfile_mp_scoreboard #(
        .AW  (AW),
        .NWR (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .resetn     (resetn),
        .we         (we),
        .waddr      (waddr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy       (busy)
    );

    // Storage writes; later ports overwrite earlier ones so the highest index wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
                end
            end
        end
    end

    // Combinational read ports with zero-register masking and optional forwarding
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        wa    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            if (ra != AW'(REG_ZERO)) begin
                rdata[i*DW +: DW] = mem[ra];
                rbusy[i]          = busy[ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    wa = waddr[j*AW +: AW];
                    if (we[j] && (wa == ra)) begin
                        rdata[i*DW +: DW] = wdata[j*DW +: DW];
                        rbusy[i]          = 1'b0;
                    end
                end
`else
                wa = '0;
`endif
            end
        end
    end

endmodule
